seg7_scan_capture: RTL and testbench

Receive-side monitor for the 4-digit multiplexed 7-segment bus (active-low anode select plus active-low segment/dp lines).
- Samples the scanned anode/segment stream and debounces each digit dwell.
- Decodes segment patterns back to digit codes and assembles complete frames.
- Publishes each frame with a one-cycle strobe.
- Sits between the display driver outputs and the self-check/readback logic, so meter readings and the dash-pattern state can be checked numerically.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_pattern_decode.sv | 34 +++
 rtl/seg7_scan_capture.sv | 205 ++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Package for the 7-segment scan capture slice.
// Holds the active-low segment patterns (DISP[6:0] = g..a) for the ten digits,
// the dash and the lit-but-empty pattern, the published code constants, and
// the frame-assembly state enum shared by the capture top.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BAD   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } frame_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low 7-segment pattern back to a digit code.
// Ports:
//   SEG  in  7  segment pattern, active-low, bit 6 = g .. bit 0 = a
//   CODE out 4  0..9 for digits, A for dash, F for lit-but-empty, E otherwise
//   BAD  out 1  high when the pattern is not one of the recognised shapes
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] SEG,
    output logic [3:0] CODE,
    output logic       BAD
);

    always_comb begin
        CODE = CODE_BAD;
        BAD  = 1'b0;
        case (SEG)
            SEG_0:    CODE = 4'h0;
            SEG_1:    CODE = 4'h1;
            SEG_2:    CODE = 4'h2;
            SEG_3:    CODE = 4'h3;
            SEG_4:    CODE = 4'h4;
            SEG_5:    CODE = 4'h5;
            SEG_6:    CODE = 4'h6;
            SEG_7:    CODE = 4'h7;
            SEG_8:    CODE = 4'h8;
            SEG_9:    CODE = 4'h9;
            SEG_DASH: CODE = CODE_DASH;
            SEG_OFF:  CODE = CODE_BLANK;
            default:  BAD  = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment bus. Debounces each
// digit dwell, decodes it back to a code, assembles complete frames and
// publishes each frame with a one-cycle strobe.
// Ports:
//   CLK         in  1   system clock, rising edge
//   RST_N       in  1   synchronous active-low reset
//   AN          in  4   anode selects, active-low, AN[i]=0 selects slot i
//   DISP        in  8   segments, active-low, DISP[7]=dp, DISP[6:0]=g..a
//   DIGITS      out 16  published codes, slot i in [4i+3:4i]
//   DP          out 4   published decimal points, active-high
//   FRAME_VALID out 1   one-cycle pulse per publish
//   FRAME_ERR   out 1   published frame saw a bad pattern or multi-anode sample
//   STALE       out 1   no accepted dwell within TIMEOUT cycles
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  AN,
    input  logic [7:0]  DISP,
    output logic [15:0] DIGITS,
    output logic [3:0]  DP,
    output logic        FRAME_VALID,
    output logic        FRAME_ERR,
    output logic        STALE
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]    an_meta, an_s, prev_an;
    logic [7:0]    disp_meta, disp_s, prev_disp;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] idle_cnt;

    logic [3:0]  slot_mask;
    logic        sample_valid, sample_idle, sample_illegal, same_sample;
    logic        accept, timeout_edge, slot_seen, err_now;
    logic [3:0]  dec_code;
    logic        dec_bad;

    logic [15:0] shadow_code;
    logic [3:0]  shadow_dp;
    logic [3:0]  seen;
    logic        err_flag;
    logic [15:0] pub_digits;

    frame_state_t state, next_state;
    logic         do_boundary, do_flush, publish;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            an_meta   <= 4'hF;
            an_s      <= 4'hF;
            disp_meta <= 8'hFF;
            disp_s    <= 8'hFF;
            prev_an   <= 4'hF;
            prev_disp <= 8'hFF;
        end else begin
            an_meta   <= AN;
            an_s      <= an_meta;
            disp_meta <= DISP;
            disp_s    <= disp_meta;
            prev_an   <= an_s;
            prev_disp <= disp_s;
        end
    end

    // A valid sample has exactly one anode low; the inverted anodes then form
    // a one-hot slot mask, so no slot index is ever needed.
    assign slot_mask      = ~an_s;
    assign sample_idle    = (an_s == 4'hF);
    assign sample_valid   = !sample_idle && ((slot_mask & (slot_mask - 4'd1)) == 4'd0);
    assign sample_illegal = !sample_idle && !sample_valid;
    assign same_sample    = ({an_s, disp_s} == {prev_an, prev_disp});

    // Accept fires on the single cycle the counter steps onto STABLE_CYCLES-1;
    // the counter then saturates so a long dwell is not accepted twice.
    assign accept       = sample_valid && same_sample && (stab_cnt == SW'(STABLE_CYCLES - 2));
    assign timeout_edge = !accept && (idle_cnt == TW'(TIMEOUT - 1));
    assign slot_seen    = |(seen & slot_mask);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stab_cnt <= '0;
        end else if (sample_valid && same_sample) begin
            if (stab_cnt != SW'(STABLE_CYCLES - 1)) begin
                stab_cnt <= stab_cnt + SW'(1);
            end
        end else begin
            stab_cnt <= '0;
        end
    end

    seg7_pattern_decode u_decode (
        .SEG  (disp_s[6:0]),
        .CODE (dec_code),
        .BAD  (dec_bad)
    );

    assign err_now = sample_illegal || (accept && dec_bad);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            idle_cnt <= '0;
            STALE    <= 1'b1;
        end else if (accept) begin
            idle_cnt <= '0;
            STALE    <= 1'b0;
        end else if (idle_cnt != TW'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + TW'(1);
            if (timeout_edge) begin
                STALE <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A repeated slot closes the frame; the accept that caused it is kept in
    // the shadow as the first digit of the following frame.
    always_comb begin
        next_state  = state;
        do_boundary = 1'b0;
        do_flush    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (accept && slot_seen) begin
                    do_boundary = 1'b1;
                    next_state  = PUBLISH;
                end else if (timeout_edge) begin
                    do_flush   = 1'b1;
                    next_state = PUBLISH;
                end
            end
            PUBLISH: begin
                next_state = (accept || (seen != 4'd0)) ? COLLECT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign publish = do_boundary || do_flush;

    always_comb begin
        pub_digits = '0;
        for (int i = 0; i < 4; i++) begin
            pub_digits[4*i +: 4] = seen[i] ? shadow_code[4*i +: 4] : CODE_BLANK;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shadow_code <= 16'hFFFF;
            shadow_dp   <= 4'd0;
            seen        <= 4'd0;
            err_flag    <= 1'b0;
            DIGITS      <= 16'hFFFF;
            DP          <= 4'd0;
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            FRAME_VALID <= publish;
            // Errors seen on the publish cycle itself belong to the next frame.
            if (publish) begin
                DIGITS    <= pub_digits;
                DP        <= shadow_dp & seen;
                FRAME_ERR <= err_flag;
                err_flag  <= err_now;
            end else begin
                err_flag  <= err_flag || err_now;
            end

            if (do_flush) begin
                seen <= 4'd0;
            end else if (do_boundary) begin
                seen <= slot_mask;
            end else if (accept) begin
                seen <= seen | slot_mask;
            end

            for (int i = 0; i < 4; i++) begin
                if (accept && slot_mask[i]) begin
                    shadow_code[4*i +: 4] <= dec_code;
                    shadow_dp[i]          <= ~disp_s[7];
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture. Stimulus is a list of pin dwells
// (anodes + segments held for N cycles); a dwell-level reference model turns
// each dwell into expected published frames pushed on a queue, and a monitor
// pops and compares whenever FRAME_VALID is seen.
module tb_seg7_scan_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 100;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  AN    = 4'hF;
    logic [7:0]  DISP  = 8'hFF;
    logic [15:0] DIGITS;
    logic [3:0]  DP;
    logic        FRAME_VALID, FRAME_ERR, STALE;

    always #5 CLK = ~CLK;

    seg7_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .AN          (AN),
        .DISP        (DISP),
        .DIGITS      (DIGITS),
        .DP          (DP),
        .FRAME_VALID (FRAME_VALID),
        .FRAME_ERR   (FRAME_ERR),
        .STALE       (STALE)
    );

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        err;
        logic        stale;
    } frame_t;

    frame_t expq[$];
    int tests = 0;
    int fails = 0;

    // Reference model state: codes/dp per slot, slots present, pending error,
    // pin-time of the last accepted dwell.
    int          tnow = 0;
    logic [3:0]  m_code [4];
    logic [3:0]  m_dp, m_seen;
    logic        m_err;
    int          m_last_acc = 0;

    logic [6:0] seg_tab [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F};

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] refDecode(input logic [6:0] p);
        case (p)
            7'h40: return 5'h00;
            7'h79: return 5'h01;
            7'h24: return 5'h02;
            7'h30: return 5'h03;
            7'h19: return 5'h04;
            7'h12: return 5'h05;
            7'h02: return 5'h06;
            7'h78: return 5'h07;
            7'h00: return 5'h08;
            7'h10: return 5'h09;
            7'h3F: return 5'h0A;
            7'h7F: return 5'h0F;
            default: return 5'h1E;
        endcase
    endfunction

    task automatic modelPublish(input logic stale);
        frame_t f;
        for (int i = 0; i < 4; i++) begin
            f.digits[4*i +: 4] = m_seen[i] ? m_code[i] : 4'hF;
        end
        f.dp    = m_dp & m_seen;
        f.err   = m_err;
        f.stale = stale;
        expq.push_back(f);
        m_seen = 4'd0;
        m_err  = 1'b0;
    endtask

    task automatic modelReset();
        m_seen = 4'd0;
        m_dp   = 4'd0;
        m_err  = 1'b0;
        for (int i = 0; i < 4; i++) m_code[i] = 4'hF;
    endtask

    // A dwell of len cycles starting at pin time s is accepted at s+STABLE-1.
    // A non-empty frame is flushed at last_accept+TMO unless an accept lands
    // on or before that time.
    task automatic modelDwell(input logic [3:0] an, input logic [7:0] disp, input int len);
        int s, e, acc, f_t, zeros, idx;
        logic pending;
        logic [4:0] d;
        s       = tnow;
        e       = tnow + len - 1;
        acc     = s + STABLE - 1;
        zeros   = $countones(~an);
        f_t     = m_last_acc + TMO;
        pending = (m_seen != 4'd0);
        if (zeros == 1 && len >= STABLE) begin
            if (pending && f_t < acc) modelPublish(1'b1);
            idx = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
            if (m_seen[idx]) modelPublish(1'b0);
            d = refDecode(disp[6:0]);
            m_code[idx] = d[3:0];
            m_dp[idx]   = ~disp[7];
            m_seen[idx] = 1'b1;
            m_err       = m_err | d[4];
            m_last_acc  = acc;
        end else if (zeros > 1) begin
            if (pending && f_t <= e) begin
                if (s < f_t) m_err = 1'b1;
                modelPublish(1'b1);
            end
            m_err = 1'b1;
        end else if (pending && f_t <= e) begin
            modelPublish(1'b1);
        end
        tnow += len;
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [7:0] disp, input int len);
        modelDwell(an, disp, len);
        AN   = an;
        DISP = disp;
        repeat (len) @(posedge CLK);
        #1;
    endtask

    task automatic scanRound(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3,
                             input logic blank0);
        applyStimulus(blank0 ? 4'hF : 4'b1110, d0, 20);
        applyStimulus(4'b1101, d1, 20);
        applyStimulus(4'b1011, d2, 20);
        applyStimulus(4'b0111, d3, 20);
    endtask

    // Monitor: every publish is popped against the model's expectation.
    logic prev_valid = 1'b0;
    logic prev_stale = 1'b1;
    always @(negedge CLK) begin
        frame_t f;
        if (FRAME_VALID === 1'b1) begin
            checkOutput("fv_single_pulse", {15'd0, prev_valid}, 16'd0);
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_frame: got DIGITS=%h DP=%b, expected no publish", DIGITS, DP);
            end else begin
                f = expq.pop_front();
                checkOutput("frame_digits", DIGITS, f.digits);
                checkOutput("frame_dp", {12'd0, DP}, {12'd0, f.dp});
                checkOutput("frame_err", {15'd0, FRAME_ERR}, {15'd0, f.err});
                checkOutput("frame_stale", {15'd0, STALE}, {15'd0, f.stale});
                if (f.stale) checkOutput("stale_rise_edge", {15'd0, prev_stale}, 16'd0);
            end
        end
        prev_valid = FRAME_VALID;
        prev_stale = STALE;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] an, last_an;
        logic [7:0] disp, last_disp;
        int r, len, k;

        modelReset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_digits", DIGITS, 16'hFFFF);
        checkOutput("rst_dp", {12'd0, DP}, 16'd0);
        checkOutput("rst_valid", {15'd0, FRAME_VALID}, 16'd0);
        checkOutput("rst_err", {15'd0, FRAME_ERR}, 16'd0);
        checkOutput("rst_stale", {15'd0, STALE}, 16'd1);
        RST_N = 1'b1;
        applyStimulus(4'hF, 8'hFF, 5);

        // Digits 0,1,2,5 with dp on slot 2, two rounds, then idle to flush.
        scanRound({1'b1, 7'h40}, {1'b1, 7'h79}, {1'b0, 7'h24}, {1'b1, 7'h12}, 1'b0);
        checkOutput("stale_cleared", {15'd0, STALE}, 16'd0);
        scanRound({1'b1, 7'h40}, {1'b1, 7'h79}, {1'b0, 7'h24}, {1'b1, 7'h12}, 1'b0);
        applyStimulus(4'hF, 8'hFF, TMO + 20);
        checkOutput("stale_after_idle", {15'd0, STALE}, 16'd1);

        // Leading digit blanked by anodes held high.
        scanRound({1'b1, 7'h40}, {1'b1, 7'h79}, {1'b0, 7'h24}, {1'b1, 7'h12}, 1'b1);
        scanRound({1'b1, 7'h40}, {1'b1, 7'h79}, {1'b0, 7'h24}, {1'b1, 7'h12}, 1'b1);
        applyStimulus(4'hF, 8'hFF, TMO + 20);

        // Dash on every slot.
        scanRound(8'hBF, 8'hBF, 8'hBF, 8'hBF, 1'b0);
        scanRound(8'hBF, 8'hBF, 8'hBF, 8'hBF, 1'b0);
        applyStimulus(4'hF, 8'hFF, TMO + 20);

        // Short dwell, bad pattern and multi-anode sample in one frame.
        applyStimulus(4'b1110, {1'b1, 7'h30}, 20);
        applyStimulus(4'b1101, {1'b1, 7'h78}, STABLE - 1);
        applyStimulus(4'b1011, {1'b1, 7'h7E}, 20);
        applyStimulus(4'b1100, {1'b1, 7'h10}, 2);
        applyStimulus(4'b0111, {1'b1, 7'h10}, 20);
        applyStimulus(4'b1110, {1'b1, 7'h30}, 20);
        applyStimulus(4'hF, 8'hFF, TMO + 20);

        // Randomised dwells, including lengths around the stability threshold.
        last_an   = 4'hF;
        last_disp = 8'hFF;
        for (int blk = 0; blk < 3; blk++) begin
            for (int n = 0; n < 40; n++) begin
                r   = $urandom_range(0, 99);
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(2, 24);
                if (r < 8) begin
                    an   = 4'hF;
                    disp = 8'($urandom);
                end else if (r < 13) begin
                    an = 4'($urandom_range(0, 15));
                    for (int g = 0; g < 32 && $countones(~an) < 2; g++) an = 4'($urandom_range(0, 15));
                    if ($countones(~an) < 2) an = 4'b1100;
                    disp = 8'($urandom);
                end else begin
                    an = ~(4'b0001 << $urandom_range(0, 3));
                    k  = $urandom_range(0, 15);
                    disp[6:0] = (k < 12) ? seg_tab[k] : 7'($urandom);
                    disp[7]   = 1'($urandom);
                    if (an == last_an && disp == last_disp) disp[7] = ~disp[7];
                end
                applyStimulus(an, disp, len);
                last_an   = an;
                last_disp = disp;
            end
            applyStimulus(4'hF, 8'hFF, TMO + 20);
            last_an   = 4'hF;
            last_disp = 8'hFF;
        end

        // Reset in the middle of a frame: shadow dropped, nothing published.
        applyStimulus(4'b1110, {1'b1, 7'h30}, 10);
        applyStimulus(4'b1101, {1'b1, 7'h19}, 10);
        applyStimulus(4'hF, 8'hFF, 5);
        RST_N = 1'b0;
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("midrst_digits", DIGITS, 16'hFFFF);
        checkOutput("midrst_dp", {12'd0, DP}, 16'd0);
        checkOutput("midrst_err", {15'd0, FRAME_ERR}, 16'd0);
        checkOutput("midrst_stale", {15'd0, STALE}, 16'd1);
        RST_N = 1'b1;
        applyStimulus(4'hF, 8'hFF, TMO + 20);
        checkOutput("post_rst_digits", DIGITS, 16'hFFFF);
        checkOutput("queue_drained", 16'(expq.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
